// File: rtl/uart_rx_fifo_receiver_if.sv
// uart_rx_fifo_receiver_if: serial line, frame configuration and FIFO read/status bundle
interface uart_rx_fifo_receiver_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                              serial_data_in;
    logic [1:0]                        data_len;
    logic                              parity_enable;
    logic                              parity_type;
    logic                              two_stop_bits;
    logic [PRESCALE_WIDTH-1:0]         prescale;
    logic                              rd_en;
    logic                              clr_errors;
    logic [DATA_WIDTH-1:0]             rd_data;
    logic                              rd_parity_err;
    logic                              rd_frame_err;
    logic                              fifo_empty;
    logic                              fifo_full;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
    logic                              overrun_error;
    logic                              break_detect;

    modport master (
        output serial_data_in, data_len, parity_enable, parity_type, two_stop_bits, prescale, rd_en, clr_errors,
        input  rd_data, rd_parity_err, rd_frame_err, fifo_empty, fifo_full, fifo_count, overrun_error, break_detect
    );
    modport slave (
        input  serial_data_in, data_len, parity_enable, parity_type, two_stop_bits, prescale, rd_en, clr_errors,
        output rd_data, rd_parity_err, rd_frame_err, fifo_empty, fifo_full, fifo_count, overrun_error, break_detect
    );
endinterface

// File: rtl/uart_rx_fifo_receiver.sv
// uart_rx_fifo_receiver: oversampled UART receiver with majority voting, break detection and FWFT FIFO
module uart_rx_fifo_receiver #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic                     UCLK,
    input logic                     reset,
    uart_rx_fifo_receiver_if.slave  bus
);
    localparam int PW = PRESCALE_WIDTH;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int WW = DATA_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             sync_q, smp_q, smp_d, len_q, len_d;
    logic                   rx_s, rx_prev_q;
    logic [PW-1:0]          cnt_q, cnt_d, presc_q, presc_d, half;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   perr_q, perr_d, zero_q, zero_d, pen_q, pen_d, ptype_q, ptype_d, two_q, two_d;
    logic                   vote, at_vote, at_end, done;
    logic                   push_q, push_d, brk_q, brk_d;
    logic [WW-1:0]          word_q, word_d;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pen_d   = pen_q;
        ptype_d = ptype_q;
        two_d   = two_q;
        presc_d = presc_q;
        bit_d   = bit_q;
        data_d  = data_q;
        perr_d  = perr_q;
        zero_d  = zero_q;
        push_d  = 1'b0;
        brk_d   = 1'b0;
        word_d  = word_q;
        half    = presc_q >> 1;
        smp_d[0] = (cnt_q == half - PW'(1)) ? rx_s : smp_q[0];
        smp_d[1] = (cnt_q == half) ? rx_s : smp_q[1];
        vote    = (smp_q[0] & smp_q[1]) | (rx_s & (smp_q[0] | smp_q[1]));
        at_vote = cnt_q == half + PW'(1);
        at_end  = cnt_q == presc_q - PW'(1);
        cnt_d   = at_end ? '0 : cnt_q + PW'(1);
        done    = at_vote && (state_q == STOP2 || (state_q == STOP1 && !(two_q && vote)));
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                    len_d   = bus.data_len;
                    pen_d   = bus.parity_enable;
                    ptype_d = bus.parity_type;
                    two_d   = bus.two_stop_bits;
                    presc_d = bus.prescale;
                    bit_d   = '0;
                    data_d  = '0;
                    perr_d  = 1'b0;
                    zero_d  = 1'b1;
                end
            end
            START: state_d = (at_vote && vote) ? IDLE : at_end ? DATA : START;
            DATA: begin
                if (at_vote) begin
                    data_d[bit_q] = vote;
                    zero_d        = zero_q & ~vote;
                end
                if (at_end) begin
                    if (bit_q == BW'(len_q) + BW'(4))
                        state_d = pen_q ? PARITY : STOP1;
                    else
                        bit_d = bit_q + BW'(1);
                end
            end
            PARITY: begin
                if (at_vote) begin
                    perr_d = (^data_q ^ vote) != ptype_q;
                    zero_d = zero_q & ~vote;
                end
                if (at_end) state_d = STOP1;
            end
            STOP1: if (at_end) state_d = STOP2;
            STOP2: state_d = STOP2;
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // frame ends at the last stop-bit decision so the next start edge is never missed
        if (done) begin
            state_d = vote ? IDLE : WAIT_IDLE;
            push_d  = 1'b1;
            brk_d   = state_q == STOP1 && zero_q && !vote;
            word_d  = {!vote, perr_q, data_q};
        end
    end

    always_ff @(posedge UCLK) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            smp_q     <= 2'b11;
            cnt_q     <= '0;
            bit_q     <= '0;
            len_q     <= '0;
            pen_q     <= 1'b0;
            ptype_q   <= 1'b0;
            two_q     <= 1'b0;
            presc_q   <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            zero_q    <= 1'b0;
            push_q    <= 1'b0;
            brk_q     <= 1'b0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], bus.serial_data_in};
            rx_prev_q <= rx_s;
            smp_q     <= smp_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            len_q     <= len_d;
            pen_q     <= pen_d;
            ptype_q   <= ptype_d;
            two_q     <= two_d;
            presc_q   <= presc_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            zero_q    <= zero_d;
            push_q    <= push_d;
            brk_q     <= brk_d;
            word_q    <= word_d;
        end
    end

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] fcnt_q;
    logic          ovr_q, empty, full, pop, push;

    assign empty = fcnt_q == '0;
    assign full  = fcnt_q == CW'(FIFO_DEPTH);
    assign pop   = bus.rd_en && !empty;
    assign push  = push_q && (!full || pop);

    always_ff @(posedge UCLK) begin
        if (!reset) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            wp_q   <= wp_q + AW'(push);
            rp_q   <= rp_q + AW'(pop);
            fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
            ovr_q  <= (push_q && !push) || (ovr_q && !bus.clr_errors);
        end
    end

    always_ff @(posedge UCLK)
        if (push) mem[wp_q] <= word_q;

    assign bus.rd_data       = empty ? '0 : mem[rp_q][DATA_WIDTH-1:0];
    assign bus.rd_parity_err = !empty && mem[rp_q][DATA_WIDTH];
    assign bus.rd_frame_err  = !empty && mem[rp_q][DATA_WIDTH+1];
    assign bus.fifo_empty    = empty;
    assign bus.fifo_full     = full;
    assign bus.fifo_count    = fcnt_q;
    assign bus.overrun_error = ovr_q;
    assign bus.break_detect  = brk_q;
endmodule

// File: tb/tb_uart_rx_fifo_receiver.sv
// tb_uart_rx_fifo_receiver: directed frames at prescale 16 with hand-computed FIFO contents
module tb_uart_rx_fifo_receiver;
    localparam int P = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   brk_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_receiver_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .PRESCALE_WIDTH(6)) bus ();

    uart_rx_fifo_receiver #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .PRESCALE_WIDTH(6)) dut (
        .UCLK  (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always @(negedge clk) if (rst_n && bus.break_detect) brk_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        bus.serial_data_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] v, input int nb, input logic pen, input logic ptype,
                        input logic two, input logic flip);
        logic p;
        p = ptype ^ flip;
        for (int i = 0; i < nb; i++) p ^= v[i];
        bus.data_len      = 2'(nb - 5);
        bus.parity_enable = pen;
        bus.parity_type   = ptype;
        bus.two_stop_bits = two;
        drive(1'b0, P);
        for (int i = 0; i < nb; i++) drive(v[i], P);
        if (pen) drive(p, P);
        drive(1'b1, P);
        if (two) drive(1'b1, P);
        drive(1'b1, 2*P);
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.serial_data_in = 1'b1;
        bus.rd_en          = 1'b0;
        bus.clr_errors     = 1'b0;
        bus.data_len       = 2'b11;
        bus.parity_enable  = 1'b0;
        bus.parity_type    = 1'b0;
        bus.two_stop_bits  = 1'b0;
        bus.prescale       = 6'(P);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_data", bus.rd_data, 0);
        check("rst_perr", bus.rd_parity_err, 0);
        check("rst_ferr", bus.rd_frame_err, 0);
        check("rst_empty", bus.fifo_empty, 1);
        check("rst_full", bus.fifo_full, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_ovr", bus.overrun_error, 0);
        check("rst_brk", bus.break_detect, 0);

        send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        check("8n1_data", bus.rd_data, 32'hA5);
        check("8n1_perr", bus.rd_parity_err, 0);
        check("8n1_ferr", bus.rd_frame_err, 0);
        check("8n1_count", bus.fifo_count, 1);
        pop();
        check("8n1_empty", bus.fifo_empty, 1);

        send(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1);
        check("7e2_data", bus.rd_data, 32'h35);
        check("7e2_perr", bus.rd_parity_err, 1);
        check("7e2_ferr", bus.rd_frame_err, 0);
        pop();

        drive(1'b0, 6);
        drive(1'b1, 2*P);
        check("glitch_count", bus.fifo_count, 0);
        check("glitch_empty", bus.fifo_empty, 1);
        send(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        check("glitch_next_data", bus.rd_data, 32'h3C);
        check("glitch_next_count", bus.fifo_count, 1);
        check("glitch_next_perr", bus.rd_parity_err, 0);
        pop();

        for (int i = 0; i < 9; i++) begin
            send(8'(8'h10 + i), 8, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 7) begin
                check("fill8_full", bus.fifo_full, 1);
                check("fill8_ovr", bus.overrun_error, 0);
            end
        end
        check("ovr_full", bus.fifo_full, 1);
        check("ovr_count", bus.fifo_count, 8);
        check("ovr_flag", bus.overrun_error, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), bus.rd_data, 32'h10 + 32'(i));
            pop();
        end
        check("drain_empty", bus.fifo_empty, 1);
        check("ovr_sticky", bus.overrun_error, 1);
        bus.clr_errors = 1'b1;
        @(negedge clk);
        bus.clr_errors = 1'b0;
        check("ovr_clr", bus.overrun_error, 0);

        bus.parity_enable = 1'b1;
        bus.parity_type   = 1'b1;
        bus.data_len      = 2'b11;
        drive(1'b0, 20*P);
        check("brk_pulses", brk_cnt, 1);
        check("brk_count", bus.fifo_count, 1);
        check("brk_data", bus.rd_data, 0);
        check("brk_ferr", bus.rd_frame_err, 1);
        drive(1'b1, 2*P);
        check("brk_hold_count", bus.fifo_count, 1);
        send(8'h81, 8, 1'b1, 1'b1, 1'b0, 1'b0);
        check("brk_next_count", bus.fifo_count, 2);
        pop();
        check("brk_next_data", bus.rd_data, 32'h81);
        check("brk_next_perr", bus.rd_parity_err, 0);
        check("brk_next_ferr", bus.rd_frame_err, 0);
        check("brk_pulses_final", brk_cnt, 1);
        pop();

        bus.parity_enable = 1'b0;
        bus.data_len      = 2'b11;
        drive(1'b0, P);
        for (int i = 0; i < 4; i++) drive(1'b1, P);
        drive(1'b0, P/2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3*P);
        check("midrst_count", bus.fifo_count, 0);
        check("midrst_empty", bus.fifo_empty, 1);
        send(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_next_count", bus.fifo_count, 1);
        check("midrst_next_data", bus.rd_data, 32'h5A);
        pop();
        check("midrst_final_empty", bus.fifo_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
